// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes, funct codes
// and datapath select values.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StTrap    = 4'd12
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] SrcbRd2   = 2'b00;
    localparam logic [1:0] SrcbFour  = 2'b01;
    localparam logic [1:0] SrcbImm   = 2'b10;
    localparam logic [1:0] SrcbImmSh = 2'b11;

    localparam logic [1:0] PcsrcAlu    = 2'b00;
    localparam logic [1:0] PcsrcAluOut = 2'b01;
    localparam logic [1:0] PcsrcJump   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus an unknown-funct flag.
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       unknown
);

    always_comb begin
        alucontrol = AluAdd;
        unknown    = 1'b0;
        case (funct)
            FunctAdd: alucontrol = AluAdd;
            FunctSub: alucontrol = AluSub;
            FunctAnd: alucontrol = AluAnd;
            FunctOr:  alucontrol = AluOr;
            FunctSlt: alucontrol = AluSlt;
            default:  unknown    = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS controller (Moore FSM with mem_rdy/zero qualified enables).
// Optional overflow trap state enabled by defining MC_OVFL_TRAP_EN.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_rdy,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state_o,
    output logic       illegal_op,
    output logic       exc
);

    state_e     state_q, state_d;
    logic [2:0] dec_alu;
    logic       dec_unknown;

    alu_decoder u_alu_decoder (
        .funct      (funct),
        .alucontrol (dec_alu),
        .unknown    (dec_unknown)
    );

`ifndef MC_OVFL_TRAP_EN
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StFetch;
        else      state_q <= state_d;
    end

    assign state_o = state_q;

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SrcbRd2;
        pcsrc      = PcsrcAlu;
        alucontrol = AluAdd;
        illegal_op = 1'b0;
        exc        = 1'b0;

        case (state_q)
            StFetch: begin
                alusrcb = SrcbFour;
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                alusrcb = SrcbImmSh;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = SrcbImm;
                state_d = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_rdy) state_d = StFetch;
            end
            StExecute: begin
                alusrca    = 1'b1;
                alucontrol = dec_alu;
                illegal_op = dec_unknown;
                state_d    = StAluWb;
`ifdef MC_OVFL_TRAP_EN
                if (overflow && (funct == FunctAdd || funct == FunctSub)) state_d = StTrap;
`endif
            end
            StAluWb: begin
                // funct is still held in the instruction register, so re-decode it here
                regdst   = !dec_unknown;
                regwrite = !dec_unknown;
                state_d  = StFetch;
            end
            StBranch: begin
                alusrca    = 1'b1;
                alucontrol = AluSub;
                pcsrc      = PcsrcAluOut;
                pcwrite    = zero;
                state_d    = StFetch;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = SrcbImm;
                state_d = StAddiWb;
`ifdef MC_OVFL_TRAP_EN
                if (overflow) state_d = StTrap;
`endif
            end
            StAddiWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                pcsrc   = PcsrcJump;
                pcwrite = 1'b1;
                state_d = StFetch;
            end
`ifdef MC_OVFL_TRAP_EN
            StTrap: begin
                exc     = 1'b1;
                state_d = StTrap;
            end
`endif
            default: state_d = StFetch;
        endcase

        // Reset masks every output asynchronously, not just the state register
        if (!rst) begin
            state_d    = StFetch;
            iord       = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = SrcbRd2;
            pcsrc      = PcsrcAlu;
            alucontrol = AluAdd;
            illegal_op = 1'b0;
            exc        = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class state by state and
// compares state_o and the full control vector against hand-computed values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       mem_rdy;
    logic       iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;
    logic       illegal_op;
    logic       exc;
    logic [16:0] obs_ctl;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .overflow   (overflow),
        .mem_rdy    (mem_rdy),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state_o    (state_o),
        .illegal_op (illegal_op),
        .exc        (exc)
    );

    always #5 clk = ~clk;

    assign obs_ctl = {iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                      alusrcb, pcsrc, alucontrol, illegal_op, exc};

    // en bit order: iord irwrite pcwrite memwrite regwrite regdst memtoreg alusrca
    function automatic logic [16:0] ctl(input logic [7:0] en, input logic [1:0] b,
                                        input logic [1:0] p, input logic [2:0] a,
                                        input logic il, input logic ex);
        return {en, b, p, a, il, ex};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the current cycle #1 after inputs settle, then advances one clock
    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
        #1;
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_ctl"}, 32'(obs_ctl), 32'(c));
        @(negedge clk);
    endtask

    localparam logic [16:0] CRst   = 17'b0000_0000_00_00_010_0_0;
    localparam logic [16:0] CFWait = 17'b0000_0000_01_00_010_0_0;
    localparam logic [16:0] CFGo   = 17'b0110_0000_01_00_010_0_0;
    localparam logic [16:0] CDec   = 17'b0000_0000_11_00_010_0_0;
    localparam logic [16:0] CMAdr  = 17'b0000_0001_10_00_010_0_0;

    initial begin
        rst = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; overflow = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        cyc("reset", 4'd0, CRst);

        // fetch wait: three stalled cycles then a completing one
        rst = 1'b1;
        cyc("fwait0", 4'd0, CFWait);
        cyc("fwait1", 4'd0, CFWait);
        cyc("fwait2", 4'd0, CFWait);
        mem_rdy = 1'b1;
        cyc("fgo", 4'd0, CFGo);

        // lw
        op = 6'b100011;
        cyc("lw_dec", 4'd1, CDec);
        cyc("lw_adr", 4'd2, CMAdr);
        cyc("lw_rd", 4'd3, ctl(8'b1000_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        cyc("lw_wb", 4'd4, ctl(8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));

        // sw with a stalled write, then reset in the middle of the wait
        op = 6'b101011;
        cyc("sw_f", 4'd0, CFGo);
        cyc("sw_dec", 4'd1, CDec);
        cyc("sw_adr", 4'd2, CMAdr);
        mem_rdy = 1'b0;
        cyc("sw_wr0", 4'd5, ctl(8'b1001_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        cyc("sw_wr1", 4'd5, ctl(8'b1001_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        rst = 1'b0;
        cyc("sw_rst", 4'd0, CRst);
        rst = 1'b1;
        mem_rdy = 1'b1;

        // R-type: add, sub, slt, or, and, unknown funct
        op = 6'b000000;
        funct = 6'b100000;
        cyc("add_f", 4'd0, CFGo);
        cyc("add_dec", 4'd1, CDec);
        cyc("add_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        cyc("add_wb", 4'd7, ctl(8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        funct = 6'b100010;
        cyc("sub_f", 4'd0, CFGo);
        cyc("sub_dec", 4'd1, CDec);
        cyc("sub_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0, 1'b0));
        cyc("sub_wb", 4'd7, ctl(8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        funct = 6'b101010;
        cyc("slt_f", 4'd0, CFGo);
        cyc("slt_dec", 4'd1, CDec);
        cyc("slt_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0));
        cyc("slt_wb", 4'd7, ctl(8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        funct = 6'b100101;
        cyc("or_f", 4'd0, CFGo);
        cyc("or_dec", 4'd1, CDec);
        cyc("or_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0));
        cyc("or_wb", 4'd7, ctl(8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        funct = 6'b100100;
        cyc("and_f", 4'd0, CFGo);
        cyc("and_dec", 4'd1, CDec);
        cyc("and_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc("and_wb", 4'd7, ctl(8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        funct = 6'b111111;
        cyc("unk_f", 4'd0, CFGo);
        cyc("unk_dec", 4'd1, CDec);
        cyc("unk_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0));
        cyc("unk_wb", 4'd7, CRst);

        // beq taken then not taken
        op = 6'b000100;
        zero = 1'b1;
        cyc("beqt_f", 4'd0, CFGo);
        cyc("beqt_dec", 4'd1, CDec);
        cyc("beqt_br", 4'd8, ctl(8'b0010_0001, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0));
        zero = 1'b0;
        cyc("beqn_f", 4'd0, CFGo);
        cyc("beqn_dec", 4'd1, CDec);
        cyc("beqn_br", 4'd8, ctl(8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0));

        // addi, j, illegal opcode
        op = 6'b001000;
        cyc("addi_f", 4'd0, CFGo);
        cyc("addi_dec", 4'd1, CDec);
        cyc("addi_ex", 4'd9, CMAdr);
        cyc("addi_wb", 4'd10, ctl(8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        op = 6'b000010;
        cyc("j_f", 4'd0, CFGo);
        cyc("j_dec", 4'd1, CDec);
        cyc("j_jmp", 4'd11, ctl(8'b0010_0000, 2'b00, 2'b10, 3'b010, 1'b0, 1'b0));
        op = 6'b111111;
        cyc("ill_f", 4'd0, CFGo);
        cyc("ill_dec", 4'd1, ctl(8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1, 1'b0));

        // add with overflow
        op = 6'b000000;
        funct = 6'b100000;
        overflow = 1'b1;
        cyc("ovf_f", 4'd0, CFGo);
        cyc("ovf_dec", 4'd1, CDec);
        cyc("ovf_ex", 4'd6, ctl(8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
`ifdef MC_OVFL_TRAP_EN
        cyc("trap0", 4'd12, ctl(8'b0000_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1));
        cyc("trap1", 4'd12, ctl(8'b0000_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1));
        rst = 1'b0;
        cyc("trap_rst", 4'd0, CRst);
        rst = 1'b1;
`else
        cyc("ovf_wb", 4'd7, ctl(8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
`endif
        overflow = 1'b0;
        cyc("end_f", 4'd0, CFGo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
